latch_sequencer: RTL and testbench

//  Controller for the 4-channel set/reset latch network in BISLS_Model_Precision.
//  - Clears the latch network and arms it.
//  - Measures the spread (in LS_CLK cycles) between the first latch set and all four set.
//  - Reports first-arrival pattern, count, timeout; issues the latch clear afterwards.
//  - Sits between the test/host controller and the latch network; owns the network's reset input.

---
 rtl/ls_pkg.sv | 18 +
 rtl/ls_arrival_stamp.sv | 32 +++
 rtl/latch_sequencer.sv | 150 +++++++++++++++
 tb/tb_latch_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ls_pkg.sv
// Shared state encoding and default sizing for the latch sequencer.
package ls_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        ARMED = 3'd2,
        COUNT = 3'd3,
        DONE  = 3'd4
    } ls_state_e;

    localparam int CNT_W_DEF   = 8;
    localparam int MAX_CNT_DEF = 200;
    localparam int CLR_CYC_DEF = 2;

    localparam logic [CNT_W_DEF-1:0] STAMP_NONE = '1;

endpackage

// File: rtl/ls_arrival_stamp.sv
// Per-channel arrival stamp: records the spread counter on the first cycle the latch is seen set.
// Used only when LS_STAMP_EN is defined.
module ls_arrival_stamp #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic         track,
    input  logic         q,
    input  logic [W-1:0] count,
    output logic [W-1:0] stamp
);

    logic seen;

    // A channel already set when counting starts is stamped 0; one never set stays all-ones.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            stamp <= '0;
            seen  <= 1'b0;
        end else if (load) begin
            seen  <= q;
            stamp <= q ? '0 : '1;
        end else if (track && q && !seen) begin
            seen  <= 1'b1;
            stamp <= count;
        end
    end

endmodule

// File: rtl/latch_sequencer.sv
// Latch network controller: clears/arms the network and measures first-to-all arrival spread.
// Define LS_STAMP_EN to add per-channel arrival stamps on LS_STAMP.
module latch_sequencer
    import ls_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int MAX_CNT = MAX_CNT_DEF,
    parameter int CLR_CYC = CLR_CYC_DEF
) (
    input  logic             LS_CLK,
    input  logic             LS_RST,
    input  logic             LS_START,
    input  logic [3:0]       LS_LN_Q,
    input  logic             LS_LN_CNT_EN,
    input  logic             LS_LN_DIN_ALL,
    output logic             LS_LN_R,
    output logic             LS_BUSY,
    output logic             LS_DONE,
    output logic             LS_TIMEOUT,
    output logic [CNT_W-1:0] LS_COUNT,
    output logic [3:0]       LS_FIRST
`ifdef LS_STAMP_EN
    ,
    output logic [4*CNT_W-1:0] LS_STAMP
`endif
);

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(MAX_CNT);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_CYC - 1);

    ls_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] clr_cnt;

    // Outputs are registered alongside the next state so they line up with the state they describe.
    always_ff @(posedge LS_CLK) begin
        if (LS_RST) begin
            state      <= IDLE;
            cnt        <= '0;
            clr_cnt    <= '0;
            LS_LN_R    <= 1'b0;
            LS_BUSY    <= 1'b0;
            LS_DONE    <= 1'b0;
            LS_TIMEOUT <= 1'b0;
            LS_COUNT   <= '0;
            LS_FIRST   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (LS_START) begin
                        state      <= CLR;
                        clr_cnt    <= '0;
                        LS_LN_R    <= 1'b1;
                        LS_BUSY    <= 1'b1;
                        LS_TIMEOUT <= 1'b0;
                        LS_COUNT   <= '0;
                        LS_FIRST   <= '0;
                    end
                end
                CLR: begin
                    if (clr_cnt == CLR_LAST) begin
                        state   <= ARMED;
                        cnt     <= '0;
                        LS_LN_R <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + ONE;
                    end
                end
                ARMED: begin
                    if (LS_LN_DIN_ALL) begin
                        state    <= DONE;
                        LS_DONE  <= 1'b1;
                        LS_LN_R  <= 1'b1;
                        LS_COUNT <= '0;
                        LS_FIRST <= LS_LN_Q;
                    end else if (LS_LN_CNT_EN) begin
                        state    <= COUNT;
                        cnt      <= ONE;
                        LS_FIRST <= LS_LN_Q;
                    end else if (cnt == LIMIT) begin
                        state      <= DONE;
                        LS_DONE    <= 1'b1;
                        LS_LN_R    <= 1'b1;
                        LS_TIMEOUT <= 1'b1;
                        LS_COUNT   <= '0;
                        LS_FIRST   <= '0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                COUNT: begin
                    // All-set beats the limit when both land in the same cycle.
                    if (LS_LN_DIN_ALL) begin
                        state    <= DONE;
                        LS_DONE  <= 1'b1;
                        LS_LN_R  <= 1'b1;
                        LS_COUNT <= cnt;
                    end else if (cnt == LIMIT) begin
                        state      <= DONE;
                        LS_DONE    <= 1'b1;
                        LS_LN_R    <= 1'b1;
                        LS_TIMEOUT <= 1'b1;
                        LS_COUNT   <= LIMIT;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    LS_DONE <= 1'b0;
                    LS_LN_R <= 1'b0;
                    LS_BUSY <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    LS_DONE <= 1'b0;
                    LS_LN_R <= 1'b0;
                    LS_BUSY <= 1'b0;
                end
            endcase
        end
    end

`ifdef LS_STAMP_EN
    logic stamp_clear;
    logic stamp_load;
    logic stamp_track;

    assign stamp_clear = (state == IDLE) && LS_START;
    assign stamp_load  = (state == ARMED) && !LS_LN_DIN_ALL && LS_LN_CNT_EN;
    assign stamp_track = (state == COUNT);

    for (genvar i = 0; i < 4; i++) begin : g_stamp
        ls_arrival_stamp #(
            .W(CNT_W)
        ) u_stamp (
            .clk  (LS_CLK),
            .rst  (LS_RST),
            .clear(stamp_clear),
            .load (stamp_load),
            .track(stamp_track),
            .q    (LS_LN_Q[i]),
            .count(cnt),
            .stamp(LS_STAMP[i*CNT_W +: CNT_W])
        );
    end
`endif

endmodule

// File: tb/tb_latch_sequencer.sv
// Directed bench for latch_sequencer with a small registered-flag model of the latch network.
`timescale 1ns/1ps
module tb_latch_sequencer;
    import ls_pkg::*;

    localparam int CNT_W   = 8;
    localparam int MAX_CNT = 200;
    localparam int CLR_CYC = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [3:0]       q;
    logic             cnt_en;
    logic             din_all;
    logic             ln_r;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] count;
    logic [3:0]       first;
`ifdef LS_STAMP_EN
    logic [4*CNT_W-1:0] stamp;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // The network registers its OR/AND flags, so they lag the latch states by a cycle.
    always @(posedge clk) begin
        cnt_en  <= |q;
        din_all <= &q;
    end

    latch_sequencer #(
        .CNT_W  (CNT_W),
        .MAX_CNT(MAX_CNT),
        .CLR_CYC(CLR_CYC)
    ) dut (
        .LS_CLK       (clk),
        .LS_RST       (rst),
        .LS_START     (start),
        .LS_LN_Q      (q),
        .LS_LN_CNT_EN (cnt_en),
        .LS_LN_DIN_ALL(din_all),
        .LS_LN_R      (ln_r),
        .LS_BUSY      (busy),
        .LS_DONE      (done),
        .LS_TIMEOUT   (timeout),
        .LS_COUNT     (count),
        .LS_FIRST     (first)
`ifdef LS_STAMP_EN
        ,
        .LS_STAMP     (stamp)
`endif
    );

    task automatic start_run();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_armed(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < CLR_CYC + 4; i++) begin
            if (!ln_r && busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input int limit, output int cycles, output bit ok);
        cycles = 0;
        ok = 1'b0;
        while (cycles < limit) begin
            @(negedge clk);
            cycles++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        q = 4'b0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({ln_r, busy, done, timeout} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got ln_r/busy/done/timeout=%b want 0000", {ln_r, busy, done, timeout});
        end
        checks++;
        if ({count, first} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_results: got count=%0d first=%b want 0/0000", count, first);
        end
    endtask

    task automatic test_spread(input int gap, input logic [CNT_W-1:0] exp_count,
                               input logic exp_timeout, input logic [CNT_W-1:0] exp_stamp);
        bit ok;
        bit seen;
        int cyc;
        start_run();
        checks++;
        if (ln_r !== 1'b1) begin
            errors++;
            $display("[TB] FAIL start_latency gap=%0d: got ln_r=%b want 1", gap, ln_r);
        end
        wait_armed(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL arm_wait gap=%0d: got no ARMED want ARMED", gap);
        end
        q = 4'b0001;
        seen = 1'b0;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        cyc = 0;
        if (!seen) begin
            q = 4'b1111;
            wait_done(10, cyc, ok);
        end else begin
            ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL done_wait gap=%0d: got no DONE want DONE", gap);
        end
        if (!exp_timeout) begin
            checks++;
            if (cyc != 2) begin
                errors++;
                $display("[TB] FAIL done_latency gap=%0d: got %0d want 2", gap, cyc);
            end
        end
        checks++;
        if (count !== exp_count || timeout !== exp_timeout) begin
            errors++;
            $display("[TB] FAIL spread gap=%0d: got count=%0d timeout=%b want %0d/%b",
                     gap, count, timeout, exp_count, exp_timeout);
        end
        checks++;
        if (first !== 4'b0001 || ln_r !== 1'b1) begin
            errors++;
            $display("[TB] FAIL spread_first gap=%0d: got first=%b ln_r=%b want 0001/1", gap, first, ln_r);
        end
`ifdef LS_STAMP_EN
        checks++;
        if (stamp !== {exp_stamp, exp_stamp, exp_stamp, 8'h00}) begin
            errors++;
            $display("[TB] FAIL spread_stamp gap=%0d: got %h want %h", gap, stamp,
                     {exp_stamp, exp_stamp, exp_stamp, 8'h00});
        end
`endif
        q = 4'b0000;
        @(negedge clk);
        checks++;
        if ({done, busy, ln_r} !== 3'b000 || count !== exp_count) begin
            errors++;
            $display("[TB] FAIL spread_hold gap=%0d: got done/busy/ln_r=%b count=%0d want 000/%0d",
                     gap, {done, busy, ln_r}, count, exp_count);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout_armed();
        bit ok;
        int cyc;
        start_run();
        wait_done(400, cyc, ok);
        checks++;
        if (!ok || cyc < CLR_CYC + MAX_CNT || cyc > CLR_CYC + MAX_CNT + 1) begin
            errors++;
            $display("[TB] FAIL armed_timeout_time: got %0d cycles (done=%b) want %0d..%0d",
                     cyc, ok, CLR_CYC + MAX_CNT, CLR_CYC + MAX_CNT + 1);
        end
        checks++;
        if (timeout !== 1'b1 || count !== 8'd0 || first !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL armed_timeout: got timeout=%b count=%0d first=%b want 1/0/0000",
                     timeout, count, first);
        end
`ifdef LS_STAMP_EN
        checks++;
        if (stamp !== 32'h0) begin
            errors++;
            $display("[TB] FAIL armed_timeout_stamp: got %h want 00000000", stamp);
        end
`endif
        repeat (3) @(negedge clk);
    endtask

    task automatic test_stuck_pair();
        bit ok;
        int cyc;
        start_run();
        wait_armed(ok);
        q = 4'b0011;
        wait_done(300, cyc, ok);
        checks++;
        if (!ok || timeout !== 1'b1 || count !== 8'd200 || first !== 4'b0011) begin
            errors++;
            $display("[TB] FAIL stuck_pair: got done=%b timeout=%b count=%0d first=%b want 1/1/200/0011",
                     ok, timeout, count, first);
        end
`ifdef LS_STAMP_EN
        checks++;
        if (stamp !== {STAMP_NONE, STAMP_NONE, 8'h00, 8'h00}) begin
            errors++;
            $display("[TB] FAIL stuck_pair_stamp: got %h want ffff0000", stamp);
        end
`endif
        q = 4'b0000;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_simultaneous();
        bit ok;
        int cyc;
        start_run();
        wait_armed(ok);
        q = 4'b1111;
        wait_done(10, cyc, ok);
        checks++;
        if (!ok || cyc != 2) begin
            errors++;
            $display("[TB] FAIL simul_latency: got %0d cycles (done=%b) want 2", cyc, ok);
        end
        checks++;
        if (count !== 8'd0 || first !== 4'b1111 || timeout !== 1'b0 || ln_r !== 1'b1) begin
            errors++;
            $display("[TB] FAIL simul_result: got count=%0d first=%b timeout=%b ln_r=%b want 0/1111/0/1",
                     count, first, timeout, ln_r);
        end
`ifdef LS_STAMP_EN
        checks++;
        if (stamp !== 32'h0) begin
            errors++;
            $display("[TB] FAIL simul_stamp: got %h want 00000000", stamp);
        end
`endif
        q = 4'b0000;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_abort();
        bit ok;
        bit saw_done;
        start_run();
        wait_armed(ok);
        q = 4'b0001;
        repeat (3) @(negedge clk);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        checks++;
        if (busy !== 1'b1 || ln_r !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_ignored: got busy/ln_r/done=%b want 100", {busy, ln_r, done});
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({ln_r, busy, done, timeout} !== 4'b0000 || count !== 8'd0 || first !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL abort_clear: got flags=%b count=%0d first=%b want 0000/0/0000",
                     {ln_r, busy, done, timeout}, count, first);
        end
        rst = 1'b0;
        q = 4'b0000;
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("[TB] FAIL abort_quiet: got done/busy activity after reset want none");
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int cyc;
        int hi;
        start_run();
        wait_armed(ok);
        q = 4'b0001;
        repeat (3) @(negedge clk);
        q = 4'b1111;
        wait_done(10, cyc, ok);
        checks++;
        if (!ok || count !== 8'd3) begin
            errors++;
            $display("[TB] FAIL b2b_first_run: got done=%b count=%0d want 1/3", ok, count);
        end
        q = 4'b0000;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        checks++;
        if (ln_r !== 1'b1 || busy !== 1'b1 || count !== 8'd0 || first !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL b2b_restart: got ln_r=%b busy=%b count=%0d first=%b want 1/1/0/0000",
                     ln_r, busy, count, first);
        end
        hi = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ln_r) hi++;
            else break;
        end
        checks++;
        if (hi != CLR_CYC) begin
            errors++;
            $display("[TB] FAIL b2b_clr_width: got %0d cycles want %0d", hi, CLR_CYC);
        end
        q = 4'b1111;
        wait_done(10, cyc, ok);
        checks++;
        if (!ok || count !== 8'd0 || first !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL b2b_second_run: got done=%b count=%0d first=%b want 1/0/1111",
                     ok, count, first);
        end
        q = 4'b0000;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        q = 4'b0000;
        test_reset();
        test_spread(5, 8'd5, 1'b0, 8'd4);
        test_spread(200, 8'd200, 1'b0, 8'd199);
        test_spread(201, 8'd200, 1'b1, 8'd200);
        test_timeout_armed();
        test_stuck_pair();
        test_simultaneous();
        test_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
